// File: rtl/en_divider_bank_if.sv
// Bus bundle for en_divider_bank: global run/load control, configuration,
// per-channel control, and the generated enables plus debug state.
// The master side (controller or bench) drives control and config; the
// slave side (the divider bank) returns en_base, en_out, busy and cnt.
interface en_divider_bank_if #(
  parameter int NCH   = 4,
  parameter int CW    = 8,
  parameter int PRE_W = 8
);
  logic              en;
  logic              load;
  logic [PRE_W-1:0]  pre_div;
  logic [NCH*CW-1:0] div;
  logic [NCH*CW-1:0] phase;
  logic [NCH-1:0]    mode;
  logic [NCH-1:0]    trig;
  logic [NCH-1:0]    ch_en;
  logic              en_base;
  logic [NCH-1:0]    en_out;
  logic [NCH-1:0]    busy;
  logic [NCH*CW-1:0] cnt;

  modport master (
    output en, load, pre_div, div, phase, mode, trig, ch_en,
    input  en_base, en_out, busy, cnt
  );

  modport slave (
    input  en, load, pre_div, div, phase, mode, trig, ch_en,
    output en_base, en_out, busy, cnt
  );
endinterface

// File: rtl/en_divider_bank.sv
// Multi-channel enable generator. A programmable prescaler turns the core
// clock into a base tick; each channel divides the base tick by its own
// ratio and fires a one-clock enable at a programmable phase, either
// continuously or once per trigger. Configuration is only taken at load.
// Optional build macro: ENDIV_STRETCH_EN stretches every en_out pulse to
// two clocks (fire edge plus the following edge).
module en_divider_bank #(
  parameter int NCH   = 4,
  parameter int CW    = 8,
  parameter int PRE_W = 8
) (
  input logic              clk,
  input logic              reset,
  en_divider_bank_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  logic [PRE_W-1:0] pcnt;
  logic [PRE_W-1:0] pre_q;
  logic             base;
  logic [CW-1:0]    ccnt  [NCH];
  logic [CW-1:0]    div_q [NCH];
  logic [CW-1:0]    ph_q  [NCH];
  ch_state_t        state [NCH];
  logic [NCH-1:0]   ch_en_d;
  logic [NCH-1:0]   fire;
  logic [NCH-1:0]   en_out_q;
`ifdef ENDIV_STRETCH_EN
  logic [NCH-1:0]   fire_q;
`endif

  assign base        = bus.en & (pcnt == pre_q);
  assign bus.en_base = base;
  assign bus.en_out  = en_out_q;

  // Per-channel fire decode plus debug/status views of channel state.
  always_comb begin
    fire    = '0;
    bus.cnt = '0;
    bus.busy = '0;
    for (int i = 0; i < NCH; i++) begin
      fire[i] = base & (state[i] == RUN) & bus.ch_en[i] & (ccnt[i] == ph_q[i]);
      bus.cnt[i*CW +: CW] = ccnt[i];
      bus.busy[i] = (state[i] == RUN);
    end
  end

  // Prescaler: counts enabled clocks 0..pre_q; load restarts it with new period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt  <= '0;
      pre_q <= '0;
    end else if (bus.load) begin
      pcnt  <= '0;
      pre_q <= bus.pre_div;
    end else if (bus.en) begin
      if (pcnt == pre_q) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRE_W'(1);
      end
    end else begin
      pcnt <= pcnt;
    end
  end

  // Channel FSMs and counters; ch_en_d tracks ch_en to start continuous channels on a rising enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_en_d <= '0;
      for (int i = 0; i < NCH; i++) begin
        ccnt[i]  <= '0;
        div_q[i] <= '0;
        ph_q[i]  <= '0;
        state[i] <= IDLE;
      end
    end else begin
      ch_en_d <= bus.ch_en;
      for (int i = 0; i < NCH; i++) begin
        if (bus.load) begin
          ccnt[i]  <= '0;
          div_q[i] <= bus.div[i*CW +: CW];
          ph_q[i]  <= bus.phase[i*CW +: CW];
          // Continuous channels that are enabled start right away; one-shots wait for a trigger.
          state[i] <= (!bus.mode[i] && bus.ch_en[i]) ? RUN : IDLE;
        end else begin
          case (state[i])
            IDLE: begin
              if (bus.ch_en[i] && ((bus.mode[i] && bus.trig[i]) ||
                                   (!bus.mode[i] && !ch_en_d[i]))) begin
                state[i] <= RUN;
                ccnt[i]  <= '0;
              end else begin
                state[i] <= IDLE;
              end
            end
            RUN: begin
              if (base && bus.ch_en[i]) begin
                if (ccnt[i] == div_q[i]) begin
                  ccnt[i] <= '0;
                end else begin
                  ccnt[i] <= ccnt[i] + CW'(1);
                end
              end else begin
                ccnt[i] <= ccnt[i];
              end
              // A one-shot retires on the edge that produces its pulse.
              if (fire[i] && bus.mode[i]) begin
                state[i] <= IDLE;
              end else begin
                state[i] <= RUN;
              end
            end
            default: begin
              state[i] <= IDLE;
              ccnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

  // Output register: one clock of latency after the fire condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_out_q <= '0;
`ifdef ENDIV_STRETCH_EN
      fire_q   <= '0;
`endif
    end else if (bus.load) begin
      en_out_q <= '0;
`ifdef ENDIV_STRETCH_EN
      fire_q   <= '0;
`endif
    end else begin
`ifdef ENDIV_STRETCH_EN
      fire_q   <= fire;
      en_out_q <= fire | fire_q;
`else
      en_out_q <= fire;
`endif
    end
  end

endmodule
